// File: rtl/if_stage.sv
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage with the IF/ID pipeline register.
//             Optional performance counters are enabled with `PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirTarget,
    output logic [31:0] Iaddr,
    input  logic [31:0] IM_Instr,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    localparam logic [31:0] c_PC_STEP    = 32'h0000_0004;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;

    logic [31:0] w_redir_pc;

    // Low two target bits are discarded: fetches are always word aligned.
    assign w_redir_pc = RedirTarget & c_ALIGN_MASK;

    // Priority: a redirect from an older branch kills whatever stall is pending.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (Redirect) begin
            r_pc          <= w_redir_pc;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (!Stall) begin
            r_pc          <= r_pc + c_PC_STEP;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= IM_Instr;
            r_if_id_valid <= 1'b1;
        end
    end

    assign Iaddr       = r_pc;
    assign IF_ID_PC    = r_if_id_pc;
    assign IF_ID_Instr = r_if_id_instr;
    assign IF_ID_Valid = r_if_id_valid;

`ifdef PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating counters; only Reset clears them.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cnt <= 32'h0000_0000;
            r_flush_cnt <= 32'h0000_0000;
        end else begin
            if (Stall && !Redirect && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'h0000_0001;
            if (Redirect && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'h0000_0001;
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed self-checking bench for if_stage (RESET_PC = 0x3000).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirTarget;
    logic [31:0] Iaddr;
    logic [31:0] IM_Instr;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
`ifdef PERF_CNT_EN
    logic [31:0] StallCnt;
    logic [31:0] FlushCnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    if_stage #(
        .RESET_PC  (32'h0000_3000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall       (Stall),
        .Redirect    (Redirect),
        .RedirTarget (RedirTarget),
        .Iaddr       (Iaddr),
        .IM_Instr    (IM_Instr),
        .IF_ID_PC    (IF_ID_PC),
        .IF_ID_Instr (IF_ID_Instr),
        .IF_ID_Valid (IF_ID_Valid)
`ifdef PERF_CNT_EN
        ,
        .StallCnt    (StallCnt),
        .FlushCnt    (FlushCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory: word at address A is A + 0x1000_0000.
    assign IM_Instr = Iaddr + 32'h1000_0000;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirTarget = 32'h0;
        step(); step();
        n_vec++; if (Iaddr !== 32'h0000_3000) begin n_err++; $display("FAIL reset_iaddr got %h want %h", Iaddr, 32'h3000); end
        n_vec++; if (IF_ID_PC !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", IF_ID_PC, 32'h0); end
        Reset = 1'b0;
        #1;
        n_vec++; if (IF_ID_Instr !== 32'h13) begin n_err++; $display("FAIL reset_instr got %h want %h", IF_ID_Instr, 32'h13); end
        n_vec++; if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", IF_ID_Valid); end
        step();
        n_vec++; if (IF_ID_PC !== 32'h3000) begin n_err++; $display("FAIL first_fetch_pc got %h want %h", IF_ID_PC, 32'h3000); end
        n_vec++; if (IF_ID_Instr !== 32'h1000_3000) begin n_err++; $display("FAIL first_fetch_instr got %h want %h", IF_ID_Instr, 32'h1000_3000); end
        step(); step();
        n_vec++; if (Iaddr !== 32'h300C) begin n_err++; $display("FAIL run3_iaddr got %h want %h", Iaddr, 32'h300C); end
        n_vec++; if (IF_ID_PC !== 32'h3008) begin n_err++; $display("FAIL run3_pc got %h want %h", IF_ID_PC, 32'h3008); end
        n_vec++; if (IF_ID_Instr !== 32'h1000_3008) begin n_err++; $display("FAIL run3_instr got %h want %h", IF_ID_Instr, 32'h1000_3008); end
        n_vec++; if (IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL run3_valid got %b want 1", IF_ID_Valid); end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (Iaddr !== 32'h300C) begin n_err++; $display("FAIL stall_iaddr[%0d] got %h want %h", i, Iaddr, 32'h300C); end
            n_vec++; if (IF_ID_PC !== 32'h3008) begin n_err++; $display("FAIL stall_pc[%0d] got %h want %h", i, IF_ID_PC, 32'h3008); end
            n_vec++; if (IF_ID_Instr !== 32'h1000_3008) begin n_err++; $display("FAIL stall_instr[%0d] got %h want %h", i, IF_ID_Instr, 32'h1000_3008); end
            n_vec++; if (IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", i, IF_ID_Valid); end
        end
        Stall = 1'b0;
        step();
        n_vec++; if (Iaddr !== 32'h3010) begin n_err++; $display("FAIL unstall_iaddr got %h want %h", Iaddr, 32'h3010); end
        n_vec++; if (IF_ID_PC !== 32'h300C) begin n_err++; $display("FAIL unstall_pc got %h want %h", IF_ID_PC, 32'h300C); end
    endtask

    task automatic test_redirect();
        Redirect = 1'b1; RedirTarget = 32'h3103;
        step();
        Redirect = 1'b0;
        n_vec++; if (Iaddr !== 32'h3100) begin n_err++; $display("FAIL redir_iaddr got %h want %h", Iaddr, 32'h3100); end
        n_vec++; if (IF_ID_Instr !== 32'h13) begin n_err++; $display("FAIL redir_instr got %h want %h", IF_ID_Instr, 32'h13); end
        n_vec++; if (IF_ID_PC !== 32'h0) begin n_err++; $display("FAIL redir_pc got %h want %h", IF_ID_PC, 32'h0); end
        n_vec++; if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got %b want 0", IF_ID_Valid); end
        step();
        n_vec++; if (IF_ID_PC !== 32'h3100) begin n_err++; $display("FAIL redir_run_pc got %h want %h", IF_ID_PC, 32'h3100); end
        n_vec++; if (IF_ID_Instr !== 32'h1000_3100) begin n_err++; $display("FAIL redir_run_instr got %h want %h", IF_ID_Instr, 32'h1000_3100); end
        n_vec++; if (IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL redir_run_valid got %b want 1", IF_ID_Valid); end
        n_vec++; if (Iaddr !== 32'h3104) begin n_err++; $display("FAIL redir_run_iaddr got %h want %h", Iaddr, 32'h3104); end
    endtask

    task automatic test_redirect_stall();
        Redirect = 1'b1; Stall = 1'b1; RedirTarget = 32'h4000;
        step();
        Redirect = 1'b0;
        n_vec++; if (Iaddr !== 32'h4000) begin n_err++; $display("FAIL rs_iaddr got %h want %h", Iaddr, 32'h4000); end
        n_vec++; if (IF_ID_Instr !== 32'h13) begin n_err++; $display("FAIL rs_instr got %h want %h", IF_ID_Instr, 32'h13); end
        n_vec++; if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rs_valid got %b want 0", IF_ID_Valid); end
        step();
        n_vec++; if (Iaddr !== 32'h4000) begin n_err++; $display("FAIL rs_hold_iaddr got %h want %h", Iaddr, 32'h4000); end
        n_vec++; if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rs_hold_valid got %b want 0", IF_ID_Valid); end
        Stall = 1'b0;
        step();
        n_vec++; if (IF_ID_PC !== 32'h4000) begin n_err++; $display("FAIL rs_run_pc got %h want %h", IF_ID_PC, 32'h4000); end
        n_vec++; if (IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL rs_run_valid got %b want 1", IF_ID_Valid); end
    endtask

    task automatic test_wrap();
        Redirect = 1'b1; RedirTarget = 32'hFFFF_FFFE;
        step();
        Redirect = 1'b0;
        n_vec++; if (Iaddr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_target got %h want %h", Iaddr, 32'hFFFF_FFFC); end
        step();
        n_vec++; if (Iaddr !== 32'h0) begin n_err++; $display("FAIL wrap_iaddr got %h want %h", Iaddr, 32'h0); end
        n_vec++; if (IF_ID_PC !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got %h want %h", IF_ID_PC, 32'hFFFF_FFFC); end
        n_vec++; if (IF_ID_Instr !== 32'h0FFF_FFFC) begin n_err++; $display("FAIL wrap_instr got %h want %h", IF_ID_Instr, 32'h0FFF_FFFC); end
    endtask

    task automatic test_async_reset();
        Stall = 1'b1;
        step(); step();
        #2;
        Reset = 1'b1;
        #1;
        n_vec++; if (Iaddr !== 32'h3000) begin n_err++; $display("FAIL areset_iaddr got %h want %h", Iaddr, 32'h3000); end
        n_vec++; if (IF_ID_PC !== 32'h0) begin n_err++; $display("FAIL areset_pc got %h want %h", IF_ID_PC, 32'h0); end
        n_vec++; if (IF_ID_Instr !== 32'h13) begin n_err++; $display("FAIL areset_instr got %h want %h", IF_ID_Instr, 32'h13); end
        n_vec++; if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b want 0", IF_ID_Valid); end
        #1;
        Reset = 1'b0;
        Stall = 1'b0;
        step();
        n_vec++; if (IF_ID_PC !== 32'h3000) begin n_err++; $display("FAIL areset_run_pc got %h want %h", IF_ID_PC, 32'h3000); end
        n_vec++; if (Iaddr !== 32'h3004) begin n_err++; $display("FAIL areset_run_iaddr got %h want %h", Iaddr, 32'h3004); end
    endtask

`ifdef PERF_CNT_EN
    task automatic test_perf_cnt();
        Reset = 1'b1; #2; Reset = 1'b0;
        n_vec++; if (StallCnt !== 32'h0) begin n_err++; $display("FAIL cnt_clr_stall got %0d want 0", StallCnt); end
        n_vec++; if (FlushCnt !== 32'h0) begin n_err++; $display("FAIL cnt_clr_flush got %0d want 0", FlushCnt); end
        step();
        Stall = 1'b1;
        step(); step(); step();
        Redirect = 1'b1; RedirTarget = 32'h5000;
        step();
        Stall = 1'b0;
        step();
        Redirect = 1'b0;
        step();
        n_vec++; if (StallCnt !== 32'd3) begin n_err++; $display("FAIL cnt_stall got %0d want 3", StallCnt); end
        n_vec++; if (FlushCnt !== 32'd2) begin n_err++; $display("FAIL cnt_flush got %0d want 2", FlushCnt); end
        #2; Reset = 1'b1; #1;
        n_vec++; if (StallCnt !== 32'h0) begin n_err++; $display("FAIL cnt_rst_stall got %0d want 0", StallCnt); end
        n_vec++; if (FlushCnt !== 32'h0) begin n_err++; $display("FAIL cnt_rst_flush got %0d want 0", FlushCnt); end
        Reset = 1'b0;
    endtask
`endif

    initial begin
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirTarget = 32'h0;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
`ifdef PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
